// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo execution units.
// Holds the default operand/tag widths and the add/sub op encoding.
package tomasulo_pkg;

    localparam int TAG_W_DEFAULT  = 3;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/add_pipe_stage.sv
// One slot of the adder result pipeline: valid/tag/data/carry register with a hold enable.
// While i_hold is high the slot keeps its contents.
module add_pipe_stage
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int TAG_W  = TAG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hold,
    input  logic              i_valid,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_carry,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data,
    output logic              o_carry
);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic              r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
            r_data  <= i_data;
            r_carry <= i_carry;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;
    assign o_carry = r_carry;

endmodule

// File: rtl/add_pipe_unit.sv
// Pipelined add/sub functional unit: LAT-deep shift pipeline that broadcasts results on the CDB.
// Define ADD_PIPE_SUB_EN to honour in_sub; otherwise every op is an add and in_sub is ignored.
module add_pipe_unit
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int TAG_W  = TAG_W_DEFAULT,
    parameter int LAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [DATA_W-1:0]          in_op1,
    input  logic [DATA_W-1:0]          in_op2,
    input  logic                       in_sub,
    output logic                       cdb_valid,
    input  logic                       cdb_grant,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic                       cdb_carry,
    output logic                       busy,
    output logic [$clog2(LAT+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(LAT+1);

    logic              w_stall;
    logic              w_accept;
    logic              w_retire;
    logic [DATA_W:0]   w_sum;
    logic [OCC_W-1:0]  r_occupancy;

    logic              w_stValid [LAT];
    logic [TAG_W-1:0]  w_stTag   [LAT];
    logic [DATA_W-1:0] w_stData  [LAT];
    logic              w_stCarry [LAT];

`ifdef ADD_PIPE_SUB_EN
    op_e               w_op;
    logic              w_isSub;
    logic [DATA_W-1:0] w_op2Eff;

    // Subtract is op1 + ~op2 + 1, so the carry-out reads as "no borrow".
    assign w_op     = op_e'(in_sub);
    assign w_isSub  = (w_op == OP_SUB);
    assign w_op2Eff = w_isSub ? ~in_op2 : in_op2;
    assign w_sum    = {1'b0, in_op1} + {1'b0, w_op2Eff} + {{DATA_W{1'b0}}, w_isSub};
`else
    logic w_unusedSub;

    assign w_unusedSub = in_sub;
    assign w_sum       = {1'b0, in_op1} + {1'b0, in_op2};
`endif

    assign cdb_valid = w_stValid[LAT-1];
    assign w_stall   = cdb_valid && !cdb_grant;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = cdb_valid && cdb_grant;

    // The whole pipeline advances together unless the head result is waiting on the CDB.
    for (genvar s = 0; s < LAT; s++) begin : gStage
        logic              w_dValid;
        logic [TAG_W-1:0]  w_dTag;
        logic [DATA_W-1:0] w_dData;
        logic              w_dCarry;

        if (s == 0) begin : gHead
            assign w_dValid = w_accept;
            assign w_dTag   = w_accept ? in_tag : '0;
            assign w_dData  = w_accept ? w_sum[DATA_W-1:0] : '0;
            assign w_dCarry = w_accept ? w_sum[DATA_W] : 1'b0;
        end else begin : gTail
            assign w_dValid = w_stValid[s-1];
            assign w_dTag   = w_stTag[s-1];
            assign w_dData  = w_stData[s-1];
            assign w_dCarry = w_stCarry[s-1];
        end

        add_pipe_stage #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) uStage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_hold  (w_stall),
            .i_valid (w_dValid),
            .i_tag   (w_dTag),
            .i_data  (w_dData),
            .i_carry (w_dCarry),
            .o_valid (w_stValid[s]),
            .o_tag   (w_stTag[s]),
            .o_data  (w_stData[s]),
            .o_carry (w_stCarry[s])
        );
    end

    assign cdb_tag   = cdb_valid ? w_stTag[LAT-1]   : '0;
    assign cdb_data  = cdb_valid ? w_stData[LAT-1]  : '0;
    assign cdb_carry = cdb_valid ? w_stCarry[LAT-1] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupancy <= '0;
        end else if (w_accept && !w_retire) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (w_retire && !w_accept) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

    assign occupancy = r_occupancy;
    assign busy      = (r_occupancy != '0);

endmodule

// File: tb/tb_add_pipe_unit.sv
// Bench driving LAT=1, LAT=2 and LAT=4 instances with shared stimulus.
// Each instance is compared every cycle against a model of in-flight ops and their ages.
module tb_add_pipe_unit;

    localparam int NDUT = 3;

`ifdef ADD_PIPE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid;
    logic       inSub;
    logic       cdbGrant;
    logic [2:0] inTag;
    logic [7:0] inOp1;
    logic [7:0] inOp2;

    logic       inReady  [NDUT];
    logic       cdbValid [NDUT];
    logic [2:0] cdbTag   [NDUT];
    logic [7:0] cdbData  [NDUT];
    logic       cdbCarry [NDUT];
    logic       busyOut  [NDUT];
    logic [2:0] occ      [NDUT];

    int checks = 0;
    int errors = 0;

    // Model: ordered list of in-flight ops, each with the number of pipeline advances since issue.
    int         mCount [NDUT];
    logic [2:0] mTag   [NDUT][8];
    logic [7:0] mData  [NDUT][8];
    logic       mCarry [NDUT][8];
    int         mAge   [NDUT][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [$clog2(L+1)-1:0] occLocal;

        add_pipe_unit #(
            .DATA_W (8),
            .TAG_W  (3),
            .LAT    (L)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (inValid),
            .in_ready  (inReady[g]),
            .in_tag    (inTag),
            .in_op1    (inOp1),
            .in_op2    (inOp2),
            .in_sub    (inSub),
            .cdb_valid (cdbValid[g]),
            .cdb_grant (cdbGrant),
            .cdb_tag   (cdbTag[g]),
            .cdb_data  (cdbData[g]),
            .cdb_carry (cdbCarry[g]),
            .busy      (busyOut[g]),
            .occupancy (occLocal)
        );

        assign occ[g] = 3'(occLocal);
    end

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    // Result as plain arithmetic: {carry/no-borrow, 8-bit value}.
    function automatic logic [8:0] refResult(input logic [7:0] a, input logic [7:0] b, input logic s);
        int r;
        if (s && SUB_EN) begin
            r = int'(a) - int'(b);
            return {(a >= b) ? 1'b1 : 1'b0, 8'(r & 255)};
        end
        r = int'(a) + int'(b);
        return {(r > 255) ? 1'b1 : 1'b0, 8'(r & 255)};
    endfunction

    function automatic logic expValidOf(input int k);
        return (mCount[k] > 0) && (mAge[k][0] == latOf(k) - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("%s L%0d cdb_valid", tag, latOf(k)), 32'(cdbValid[k]), 32'd0);
            checkOutput($sformatf("%s L%0d cdb_tag", tag, latOf(k)), 32'(cdbTag[k]), 32'd0);
            checkOutput($sformatf("%s L%0d cdb_data", tag, latOf(k)), 32'(cdbData[k]), 32'd0);
            checkOutput($sformatf("%s L%0d cdb_carry", tag, latOf(k)), 32'(cdbCarry[k]), 32'd0);
            checkOutput($sformatf("%s L%0d busy", tag, latOf(k)), 32'(busyOut[k]), 32'd0);
            checkOutput($sformatf("%s L%0d occupancy", tag, latOf(k)), 32'(occ[k]), 32'd0);
            checkOutput($sformatf("%s L%0d in_ready", tag, latOf(k)), 32'(inReady[k]), 32'd1);
            mCount[k] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check every instance, then advance the model.
    task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [7:0] a,
                                 input logic [7:0] b, input logic s, input logic g);
        logic       ev;
        logic       stall;
        logic [8:0] res;
        inValid  = v;
        inTag    = t;
        inOp1    = a;
        inOp2    = b;
        inSub    = s;
        cdbGrant = g;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            ev    = expValidOf(k);
            stall = ev && !g;
            checkOutput($sformatf("L%0d cdb_valid", latOf(k)), 32'(cdbValid[k]), 32'(ev));
            checkOutput($sformatf("L%0d cdb_tag", latOf(k)), 32'(cdbTag[k]), ev ? 32'(mTag[k][0]) : 32'd0);
            checkOutput($sformatf("L%0d cdb_data", latOf(k)), 32'(cdbData[k]), ev ? 32'(mData[k][0]) : 32'd0);
            checkOutput($sformatf("L%0d cdb_carry", latOf(k)), 32'(cdbCarry[k]), ev ? 32'(mCarry[k][0]) : 32'd0);
            checkOutput($sformatf("L%0d in_ready", latOf(k)), 32'(inReady[k]), 32'(!stall));
            checkOutput($sformatf("L%0d busy", latOf(k)), 32'(busyOut[k]), 32'(mCount[k] != 0));
            checkOutput($sformatf("L%0d occupancy", latOf(k)), 32'(occ[k]), 32'(mCount[k]));
            if (!stall) begin
                if (ev) begin
                    for (int i = 0; i < mCount[k] - 1; i++) begin
                        mTag[k][i]   = mTag[k][i+1];
                        mData[k][i]  = mData[k][i+1];
                        mCarry[k][i] = mCarry[k][i+1];
                        mAge[k][i]   = mAge[k][i+1];
                    end
                    mCount[k]--;
                end
                for (int i = 0; i < mCount[k]; i++) mAge[k][i]++;
                if (v) begin
                    res = refResult(a, b, s);
                    mTag[k][mCount[k]]   = t;
                    mData[k][mCount[k]]  = res[7:0];
                    mCarry[k][mCount[k]] = res[8];
                    mAge[k][mCount[k]]   = 0;
                    mCount[k]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    endtask

    // Assert reset between edges, check outputs clear immediately, release on a falling edge.
    task automatic resetMid(input string tag);
        #2;
        rst_n   = 1'b0;
        inValid = 1'b0;
        #1;
        checkResetState(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  mask;
        logic [11:0] seq;
        logic [2:0]  peak;
        logic [2:0]  savedTag;
        logic [7:0]  savedData;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        inTag    = 3'd0;
        inOp1    = 8'd0;
        inOp2    = 8'd0;
        inSub    = 1'b0;
        cdbGrant = 1'b1;
        #2;
        checkResetState("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Issue on the first edge after release: 0x0F + 0x01, tag 5.
        applyStimulus(1'b1, 3'd5, 8'h0F, 8'h01, 1'b0, 1'b1);
        checkOutput("add1 L2 valid after one edge", 32'(cdbValid[1]), 32'd0);
        checkOutput("add1 L1 valid after one edge", 32'(cdbValid[0]), 32'd1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("add1 L2 valid", 32'(cdbValid[1]), 32'd1);
        checkOutput("add1 L2 tag", 32'(cdbTag[1]), 32'd5);
        checkOutput("add1 L2 data", 32'(cdbData[1]), 32'h10);
        checkOutput("add1 L2 carry", 32'(cdbCarry[1]), 32'd0);
        idle(1);

        applyStimulus(1'b1, 3'd6, 8'hFF, 8'h02, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("add2 L2 tag", 32'(cdbTag[1]), 32'd6);
        checkOutput("add2 L2 data", 32'(cdbData[1]), 32'h01);
        checkOutput("add2 L2 carry", 32'(cdbCarry[1]), 32'd1);
        idle(1);

`ifdef ADD_PIPE_SUB_EN
        applyStimulus(1'b1, 3'd7, 8'h03, 8'h05, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("sub L2 data", 32'(cdbData[1]), 32'hFE);
        checkOutput("sub L2 carry", 32'(cdbCarry[1]), 32'd0);
        idle(1);
`endif
        idle(4);

        // Back-to-back issue of tags 1..4 with the bus always granting.
        mask = '0;
        seq  = '0;
        peak = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(1'b1, 3'(i + 1), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
            else       applyStimulus(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
            checkOutput("b2b L2 in_ready", 32'(inReady[1]), 32'd1);
            if (cdbValid[1]) begin
                mask[i] = 1'b1;
                seq     = {seq[8:0], cdbTag[1]};
            end
            if (occ[1] > peak) peak = occ[1];
        end
        checkOutput("b2b L2 valid pattern", 32'(mask), 32'(7'b0011110));
        checkOutput("b2b L2 tag order", 32'(seq), 32'({3'd1, 3'd2, 3'd3, 3'd4}));
        checkOutput("b2b L2 peak occupancy", 32'(peak), 32'd2);
        idle(4);

        // Grant withheld for three cycles while new issues are offered and must be ignored.
        applyStimulus(1'b1, 3'd2, 8'h21, 8'h34, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        savedTag  = cdbTag[1];
        savedData = cdbData[1];
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'd7, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            checkOutput("stall L2 in_ready", 32'(inReady[1]), 32'd0);
            checkOutput("stall L2 cdb_valid", 32'(cdbValid[1]), 32'd1);
            checkOutput("stall L2 cdb_tag", 32'(cdbTag[1]), 32'(savedTag));
            checkOutput("stall L2 cdb_data", 32'(cdbData[1]), 32'(savedData));
        end
        idle(6);

        // Sustained stall: every build fills to exactly LAT entries.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("sat L%0d occupancy", latOf(k)), 32'(occ[k]), 32'(latOf(k)));
        end
        idle(8);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("drain L%0d occupancy", latOf(k)), 32'(occ[k]), 32'd0);
        end

        // Reset with two ops in flight in the LAT=2 unit; nothing from before may reappear.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'(i + 3), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        checkOutput("prereset L2 occupancy", 32'(occ[1]), 32'd2);
        resetMid("midreset");
        applyStimulus(1'b1, 3'd1, 8'h40, 8'h02, 1'b0, 1'b1);
        idle(6);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) resetMid("randreset");
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 3'($urandom), 8'($urandom),
                          8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_pipe_unit.md
ADD_PIPE_UNIT -- requirements
Module: add_pipe_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width (>=2).
REQ-002 SHALL have parameter TAG_W, default 3, reservation-station tag width.
REQ-003 SHALL have parameter LAT, default 2, pipeline depth in cycles (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  issue request from reservation station.
REQ-007 SHALL have port in_ready  output  1  unit accepts issue this cycle.
REQ-008 SHALL have port in_tag  input  TAG_W  tag of issuing station.
REQ-009 SHALL have port in_op1 / in_op2  input  DATA_W  operands.
REQ-010 SHALL have port in_sub  input  1  1 = subtract (op1-op2), 0 = add.
REQ-011 SHALL have port cdb_valid  output  1  result presented to common data bus.
REQ-012 SHALL have port cdb_grant  input  1  CDB arbiter accepts presented result.
REQ-013 SHALL have port cdb_tag  output  TAG_W  tag of presented result.
REQ-014 SHALL have port cdb_data  output  DATA_W  result, modulo 2^DATA_W.
REQ-015 SHALL have port cdb_carry  output  1  carry-out (add) / no-borrow (sub).
REQ-016 SHALL have port busy  output  1  any stage holds a valid op.
REQ-017 SHALL have port occupancy  output  $clog2(LAT+1)  count of in-flight ops.

Function
REQ-018 SHALL accept an op when in_valid && in_ready on a rising edge.
REQ-019 SHALL hold a LAT-entry valid/tag/data/carry shift pipeline; result computed at stage 0, carried unchanged through later stages.
REQ-020 SHALL present an op accepted at edge N on cdb_* from edge N+LAT-1 onward (cdb_valid high after LAT edges counted from acceptance inclusive) if never stalled.
REQ-021 SHALL define stall = cdb_valid && !cdb_grant; on stall every stage holds; no bubble collapse.
REQ-022 SHALL drive in_ready = !stall (combinational from cdb_grant).
REQ-023 SHALL retire the last stage when cdb_valid && cdb_grant; simultaneous retire and accept in the same edge SHALL be legal at full throughput (one op/cycle).
REQ-024 SHALL drive cdb_tag, cdb_data, cdb_carry to all-zero when cdb_valid is low (never high-Z).
REQ-025 SHALL compute sub as op1 + ~op2 + 1; cdb_carry = bit DATA_W of the (DATA_W+1)-bit sum.
REQ-026 SHALL update occupancy: +1 on accept only, -1 on retire only, unchanged on both or neither; busy = (occupancy != 0).
REQ-027 SHALL ignore in_tag/op/sub when in_valid is low or in_ready is low.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear all stage valid bits, tags, data, carries and occupancy; outputs: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_carry=0, busy=0, occupancy=0, in_ready=1.
REQ-029 SHALL discard all in-flight ops when reset asserts mid-operation; no result for them appears after release.
REQ-030 SHALL accept an issue on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL support macro ADD_PIPE_SUB_EN: defined -> in_sub honoured per REQ-025; undefined -> in_sub port present but ignored, all ops add, no subtract logic synthesised.

Structure
REQ-032 SHALL take TAG_W default, DATA_W default and op-encoding constants (OP_ADD=0, OP_SUB=1) from shared package tomasulo_pkg.
REQ-033 SHALL implement each pipeline register as sub-module add_pipe_stage (valid/tag/data/carry with hold enable), instantiated LAT times via generate.

Verification
REQ-034 SHALL cover: LAT=2, grant=1, issue tag 5, 8'h0F+8'h01 -> cdb_valid with tag 5, data 8'h10, carry 0 two edges later.
REQ-035 SHALL cover: 8'hFF+8'h02 -> data 8'h01, carry 1; with ADD_PIPE_SUB_EN, 8'h03-8'h05 -> data 8'hFE, carry 0.
REQ-036 SHALL cover: back-to-back issue tags 1,2,3,4 with grant=1 -> results on four consecutive cycles, in_ready constantly 1, occupancy peaks at 2.
REQ-037 SHALL cover: grant held 0 for 3 cycles with result pending -> in_ready=0, cdb_* stable, no op lost or duplicated after grant returns.
REQ-038 SHALL cover: rst_n low while occupancy=2 -> all outputs per REQ-028 immediately, no stale tag ever broadcast.
REQ-039 SHALL cover: LAT=1 and LAT=4 builds -> latency per REQ-020, occupancy saturates at LAT under sustained stall.
